// File: rtl/serial_tx_pkg.sv
// Shared definitions for the serial pattern transmitter: default widths and FSM state encodings.
package serial_tx_pkg;

    localparam int PAT_W_DEF = 8;
    localparam int LEN_W_DEF = 4;
    localparam int CNT_W_DEF = 4;
    localparam int GAP_W_DEF = 4;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_SEND = 2'd1;
    localparam logic [1:0] ST_GAP  = 2'd2;
    localparam logic [1:0] ST_DONE = 2'd3;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        SEND = ST_SEND,
        GAP  = ST_GAP,
        DONE = ST_DONE
    } state_e;

endpackage

// File: rtl/serial_pattern_tx_if.sv
// Request/stream bundle of the serial pattern transmitter.
// The master side issues transfers; the slave side is the transmitter.
interface serial_pattern_tx_if
    import serial_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) ();

    logic             start_valid;
    logic             start_ready;
    logic [PAT_W-1:0] pattern;
    logic [LEN_W-1:0] len;
    logic [CNT_W-1:0] repeat_n;
    logic [GAP_W-1:0] gap;
    logic             abort;
    logic             x;
    logic             x_valid;
    logic             busy;
    logic             done;

    modport master (
        output start_valid, pattern, len, repeat_n, gap, abort,
        input  start_ready, x, x_valid, busy, done
    );

    modport slave (
        input  start_valid, pattern, len, repeat_n, gap, abort,
        output start_ready, x, x_valid, busy, done
    );

endinterface

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out register, MSB-first over a len-bit field.
// bit_o is the bit that goes out in the cycle after a load or shift edge,
// so the caller can register it directly as the serial output.
module piso_shift_reg
    import serial_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             shift_en,
    input  logic [PAT_W-1:0] data,
    input  logic [LEN_W-1:0] len,
    output logic             bit_o
);

    logic [PAT_W-1:0] aligned_s;
    logic [PAT_W-1:0] shreg_d;
    logic [PAT_W-1:0] shreg_q;

    // Left-align the used field, pick the outgoing bit and compute the remaining bits.
    always_comb begin
        aligned_s = data << (LEN_W'(PAT_W) - len);
        if (load) begin
            bit_o   = aligned_s[PAT_W-1];
            shreg_d = {aligned_s[PAT_W-2:0], 1'b0};
        end else if (shift_en) begin
            bit_o   = shreg_q[PAT_W-1];
            shreg_d = {shreg_q[PAT_W-2:0], 1'b0};
        end else begin
            bit_o   = shreg_q[PAT_W-1];
            shreg_d = shreg_q;
        end
    end

    // Shift register storage, cleared by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            shreg_q <= {PAT_W{1'b0}};
        end else begin
            shreg_q <= shreg_d;
        end
    end

endmodule

// File: rtl/serial_pattern_tx.sv
// Serial pattern transmitter: sends a captured pattern MSB-first for
// repeat_n+1 passes with optional idle gaps, then pulses done.
module serial_pattern_tx
    import serial_tx_pkg::*;
#(
    parameter int PAT_W = PAT_W_DEF,
    parameter int LEN_W = LEN_W_DEF,
    parameter int CNT_W = CNT_W_DEF,
    parameter int GAP_W = GAP_W_DEF
) (
    input  logic               clk,
    input  logic               rst,
    serial_pattern_tx_if.slave bus
);

    state_e           state_d, state_q;
    logic [PAT_W-1:0] pat_d, pat_q;
    logic [LEN_W-1:0] len_d, len_q;
    logic [CNT_W-1:0] rep_d, rep_q;
    logic [GAP_W-1:0] gap_cfg_d, gap_cfg_q;
    logic [GAP_W-1:0] gap_cnt_d, gap_cnt_q;
    logic [LEN_W-1:0] idx_d, idx_q;
    logic             x_d, x_q;
    logic             x_valid_d, x_valid_q;
    logic             busy_d, busy_q;
    logic             done_d, done_q;

    logic [LEN_W-1:0] len_clamp_s;
    logic             piso_load_s;
    logic             piso_shift_s;
    logic [PAT_W-1:0] piso_data_s;
    logic [LEN_W-1:0] piso_len_s;
    logic             piso_bit_s;

    piso_shift_reg #(
        .PAT_W (PAT_W),
        .LEN_W (LEN_W)
    ) u_piso (
        .clk      (clk),
        .rst      (rst),
        .load     (piso_load_s),
        .shift_en (piso_shift_s),
        .data     (piso_data_s),
        .len      (piso_len_s),
        .bit_o    (piso_bit_s)
    );

    // Next-state, counter and registered-output logic of the transfer FSM.
    always_comb begin
        state_d      = state_q;
        pat_d        = pat_q;
        len_d        = len_q;
        rep_d        = rep_q;
        gap_cfg_d    = gap_cfg_q;
        gap_cnt_d    = gap_cnt_q;
        idx_d        = idx_q;
        x_d          = 1'b0;
        x_valid_d    = 1'b0;
        busy_d       = 1'b0;
        done_d       = 1'b0;
        piso_load_s  = 1'b0;
        piso_shift_s = 1'b0;
        // Oversized lengths are clamped to the pattern width.
        len_clamp_s  = (bus.len > LEN_W'(PAT_W)) ? LEN_W'(PAT_W) : bus.len;
        // A fresh request loads from the bus; later passes reload the captured copy.
        piso_data_s  = (state_q == IDLE) ? bus.pattern : pat_q;
        piso_len_s   = (state_q == IDLE) ? len_clamp_s : len_q;

        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (bus.start_valid && !bus.abort) begin
                        pat_d     = bus.pattern;
                        len_d     = len_clamp_s;
                        rep_d     = bus.repeat_n;
                        gap_cfg_d = bus.gap;
                        idx_d     = {LEN_W{1'b0}};
                        if (len_clamp_s == {LEN_W{1'b0}}) begin
                            state_d = DONE;
                            done_d  = 1'b1;
                        end else begin
                            state_d     = SEND;
                            piso_load_s = 1'b1;
                            x_d         = piso_bit_s;
                            x_valid_d   = 1'b1;
                            busy_d      = 1'b1;
                        end
                    end else begin
                        state_d = IDLE;
                    end
                end
                SEND: begin
                    if (idx_q != (len_q - LEN_W'(1))) begin
                        piso_shift_s = 1'b1;
                        x_d          = piso_bit_s;
                        x_valid_d    = 1'b1;
                        busy_d       = 1'b1;
                        idx_d        = idx_q + LEN_W'(1);
                    end else if (rep_q != {CNT_W{1'b0}}) begin
                        rep_d = rep_q - CNT_W'(1);
                        if (gap_cfg_q != {GAP_W{1'b0}}) begin
                            state_d   = GAP;
                            gap_cnt_d = gap_cfg_q;
                            busy_d    = 1'b1;
                        end else begin
                            // Back-to-back pass: next pass's first bit follows immediately.
                            piso_load_s = 1'b1;
                            x_d         = piso_bit_s;
                            x_valid_d   = 1'b1;
                            busy_d      = 1'b1;
                            idx_d       = {LEN_W{1'b0}};
                        end
                    end else begin
                        state_d = DONE;
                        done_d  = 1'b1;
                    end
                end
                GAP: begin
                    if (gap_cnt_q == GAP_W'(1)) begin
                        state_d     = SEND;
                        piso_load_s = 1'b1;
                        x_d         = piso_bit_s;
                        x_valid_d   = 1'b1;
                        busy_d      = 1'b1;
                        idx_d       = {LEN_W{1'b0}};
                    end else begin
                        gap_cnt_d = gap_cnt_q - GAP_W'(1);
                        busy_d    = 1'b1;
                    end
                end
                DONE: begin
                    state_d = IDLE;
                end
                default: begin
                    state_d = IDLE;
                end
            endcase
        end
    end

    // State, captured fields, counters and outputs; reset clears everything.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            pat_q     <= {PAT_W{1'b0}};
            len_q     <= {LEN_W{1'b0}};
            rep_q     <= {CNT_W{1'b0}};
            gap_cfg_q <= {GAP_W{1'b0}};
            gap_cnt_q <= {GAP_W{1'b0}};
            idx_q     <= {LEN_W{1'b0}};
            x_q       <= 1'b0;
            x_valid_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            pat_q     <= pat_d;
            len_q     <= len_d;
            rep_q     <= rep_d;
            gap_cfg_q <= gap_cfg_d;
            gap_cnt_q <= gap_cnt_d;
            idx_q     <= idx_d;
            x_q       <= x_d;
            x_valid_q <= x_valid_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
        end
    end

    assign bus.start_ready = (state_q == IDLE) && !rst;
    assign bus.x           = x_q;
    assign bus.x_valid     = x_valid_q;
    assign bus.busy        = busy_q;
    assign bus.done        = done_q;

endmodule

// File: doc/serial_pattern_tx.md
Name: serial_pattern_tx

Overview:
Serial bit-stream generator. It drives single-bit stimulus/data streams, such as the `x` input of the sequence-detecting FSMs, from a parallel pattern loaded over a valid/ready handshake. The block shifts a programmable-length pattern out MSB-first, repeats it a programmable number of times with optional idle gaps between passes, then pulses `done`. It sits upstream of any serial FSM consumer, either in a bench or as a real on-chip pattern source.

Parameters:
PAT_W, 8, maximum pattern width in bits
LEN_W, 4, width of len field (must hold PAT_W)
CNT_W, 4, width of repeat field
GAP_W, 4, width of gap field

Ports:
clk  input  1  single clock, rising edge
rst  input  1  synchronous reset, active-high
start_valid  input  1  request to start a transfer
start_ready  output  1  block can accept a request
pattern  input  PAT_W  bits to send; bits [len-1:0] are used
len  input  LEN_W  bits per pass
repeat_n  input  CNT_W  extra passes; total passes = repeat_n+1
gap  input  GAP_W  idle cycles between passes
abort  input  1  cancel the current transfer
x  output  1  serial data bit
x_valid  output  1  x carries a pattern bit this cycle
busy  output  1  transfer in progress
done  output  1  one-cycle pulse at normal completion

Behaviour:
- Reset: rst is sampled on the clk edge. Next state is IDLE with x=0, x_valid=0, busy=0, done=0. start_ready=0 while rst is high.
- Outputs x, x_valid, busy and done are registered. start_ready = (state==IDLE) && !rst.
- Handshake: a transfer is accepted when start_valid && start_ready at edge N.
  - pattern, len, repeat_n and gap are captured at edge N. Later input changes are ignored until the next accept.
  - start_valid while not IDLE is ignored. It is not queued.
- Len rules:
  - len > PAT_W is clamped to PAT_W.
  - len == 0: skip SEND and go to DONE. done pulses in cycle N+1 with no bits sent.
- FSM states: IDLE, SEND, GAP, DONE. Encode as localparams in a shared package.
  - IDLE -> SEND on accept (len != 0).
  - SEND: one bit per cycle, x = pattern[len-1-idx], x_valid=1, busy=1. The first bit is valid in cycle N+1.
  - SEND, after the last bit of a pass:
    - passes remaining and gap > 0 -> GAP.
    - passes remaining and gap == 0 -> SEND. The next pass starts back-to-back with no bubble.
    - no passes remaining -> DONE.
  - GAP: x=0, x_valid=0, busy=1 for exactly gap cycles, then SEND.
  - DONE: done=1, busy=0, x_valid=0 for one cycle, then IDLE.
- Abort:
  - Any non-IDLE state with abort=1 at an edge goes to IDLE. The next cycle has x=0, x_valid=0, busy=0, and done is not asserted.
  - abort with start_valid in IDLE: abort wins and the request is not accepted.
- Priority: rst > abort > normal operation.
- Counters:
  - Bit index counts 0..len-1.
  - Pass counter counts down from repeat_n and saturates at 0. No wrap.
  - Gap counter counts down from gap.
- Reset mid-transfer is treated like abort, plus all captured fields are cleared.

Decomposition:
- Shared package `serial_tx_pkg`: state encodings (IDLE/SEND/GAP/DONE) and default widths.
- One natural sub-module: `piso_shift_reg` (parallel-in serial-out). Interface: load, shift_en, MSB-first of a len-bit field.
- FSM and counters stay in the top module.

Test Plan:
1. PAT_W=8, pattern=8'h0B, len=4, repeat_n=0, gap=0, accepted at edge N -> x=1,0,1,1 with x_valid=1 in cycles N+1..N+4; done=1 in N+5; start_ready=1 from N+6.
2. pattern=3'b101, len=3, repeat_n=1, gap=2 -> x=1,0,1; then 2 cycles of x_valid=0; then x=1,0,1; done in cycle N+9; busy=1 in N+1..N+8.
3. pattern=2'b10, len=2, repeat_n=2, gap=0 -> x_valid stays high for 6 consecutive cycles with x=1,0,1,0,1,0; done in N+7.
4. Assert abort during the 3rd bit of test 1 -> the next cycle has x_valid=0, busy=0, no done pulse, start_ready=1. A new request then accepts normally.
5. Assert rst mid-SEND -> after the next edge: x=0, x_valid=0, busy=0, done=0, start_ready=0 while rst is high. After release, test 1 repeats correctly.
6. len=0 -> done in N+1 with no x_valid. len=9 (PAT_W=8) -> clamped, 8 bits sent. start_valid pulsed while busy -> ignored, no second transfer.
